// File: rtl/token_decoder_pkg.sv
// Shared definitions for the token decoder.
//   decoder_state : FSM encoding used by token_decoder
//   END_CODE      : code word that terminates a code sequence
//   token_shift() : log2 of a power-of-two vocab slot size
package decoder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_CODE,
    CODE,
    RD_CHAR,
    CHAR,
    NEXT,
    TERM,
    DONE
  } decoder_state;

  localparam int unsigned END_CODE = 0;

  // Slot base is code*TOKEN_LEN; TOKEN_LEN is a power of two, so this is a shift.
  function automatic int unsigned token_shift(input int unsigned len);
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) == len) s = i;
    end
    return s;
  endfunction

endpackage

// File: rtl/token_decoder.sv
// token_decoder: expands a zero-terminated list of token codes (code RAM)
// into vocab strings (vocab RAM, TOKEN_LEN bytes per slot), writing the
// characters and a final zero terminator into an output RAM.
// All RAMs are synchronous with 1-cycle read latency.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   cs           start request, sampled in IDLE only
//   code_addr    code RAM read address      / code_dout  code RAM data
//   vocab_addr   vocab RAM read address     / vocab_dout vocab RAM data
//   out_addr, out_din, out_we   output RAM write port (single-cycle pulses)
//   done         sticky, sequence fully decoded
//   overflow     sticky, output RAM filled before end of sequence
//   char_count   (only with TOKEN_DECODER_COUNT_EN) characters written,
//                terminator excluded
//
// Optional feature macro: TOKEN_DECODER_COUNT_EN
module token_decoder
  import decoder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TOKEN_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  output logic [ADDR_WIDTH-1:0] code_addr,
  input  logic [DATA_WIDTH-1:0] code_dout,
  output logic [ADDR_WIDTH-1:0] vocab_addr,
  input  logic [DATA_WIDTH-1:0] vocab_dout,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic                  out_we,
  output logic                  done,
  output logic                  overflow
`ifdef TOKEN_DECODER_COUNT_EN
  ,
  output logic [ADDR_WIDTH-1:0] char_count
`endif
);

  localparam int unsigned SHIFT = token_shift(TOKEN_LEN);
  localparam int unsigned IDX_W = SHIFT;
  localparam int unsigned WIDE  = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(TOKEN_LEN - 1);

  decoder_state          r_state;
  logic [ADDR_WIDTH-1:0] r_code_addr;
  logic [ADDR_WIDTH-1:0] r_vocab_addr;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic [DATA_WIDTH-1:0] r_out_din;
  logic                  r_out_we;
  logic                  r_done;
  logic                  r_overflow;
  logic [ADDR_WIDTH-1:0] r_out_ptr;
  logic [IDX_W-1:0]      r_char_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_code_addr  <= '0;
      r_vocab_addr <= '0;
      r_out_addr   <= '0;
      r_out_din    <= '0;
      r_out_we     <= 1'b0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_out_ptr    <= '0;
      r_char_idx   <= '0;
    end else begin
      r_out_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cs) begin
            r_code_addr <= '0;
            r_out_ptr   <= '0;
            r_state     <= RD_CODE;
          end
        end
        RD_CODE: r_state <= CODE;
        CODE: begin
          if (code_dout == DATA_WIDTH'(END_CODE)) begin
            r_state <= TERM;
          end else begin
            // Widen before shifting so the slot base is truncated only to ADDR_WIDTH.
            r_vocab_addr <= ADDR_WIDTH'(WIDE'(code_dout) << SHIFT);
            r_char_idx   <= '0;
            r_state      <= RD_CHAR;
          end
        end
        RD_CHAR: r_state <= CHAR;
        CHAR: begin
          if (vocab_dout == '0) begin
            r_state <= NEXT;
          end else if (r_out_ptr == ADDR_MAX) begin
            // Last output location is kept for the terminator.
            r_overflow <= 1'b1;
            r_state    <= TERM;
          end else begin
            r_out_we   <= 1'b1;
            r_out_addr <= r_out_ptr;
            r_out_din  <= vocab_dout;
            r_out_ptr  <= r_out_ptr + 1'b1;
            if (r_char_idx == IDX_LAST) begin
              r_state <= NEXT;
            end else begin
              r_vocab_addr <= r_vocab_addr + 1'b1;
              r_char_idx   <= r_char_idx + 1'b1;
              r_state      <= RD_CHAR;
            end
          end
        end
        NEXT: begin
          if (r_code_addr == ADDR_MAX) begin
            r_state <= TERM;
          end else begin
            r_code_addr <= r_code_addr + 1'b1;
            r_state     <= RD_CODE;
          end
        end
        TERM: begin
          r_out_we   <= 1'b1;
          r_out_addr <= r_out_ptr;
          r_out_din  <= '0;
          r_state    <= DONE;
        end
        DONE: r_done <= 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign code_addr  = r_code_addr;
  assign vocab_addr = r_vocab_addr;
  assign out_addr   = r_out_addr;
  assign out_din    = r_out_din;
  assign out_we     = r_out_we;
  assign done       = r_done;
  assign overflow   = r_overflow;
`ifdef TOKEN_DECODER_COUNT_EN
  assign char_count = r_out_ptr;
`endif

endmodule

// File: tb/tb_token_decoder.sv
// Directed self-checking bench for token_decoder with behavioural code,
// vocab and output RAMs (1-cycle read latency). Checks char_count when
// TOKEN_DECODER_COUNT_EN is defined.
module tb_token_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs  = 1'b0;
  logic [3:0] code_addr, vocab_addr, out_addr;
  logic [7:0] code_dout, vocab_dout, out_din;
  logic       out_we, done, overflow;
`ifdef TOKEN_DECODER_COUNT_EN
  logic [3:0] char_count;
`endif

  logic [7:0] code_mem  [16];
  logic [7:0] vocab_mem [16];
  logic [7:0] out_mem   [16];

  int total = 0;
  int bad   = 0;
  int we_cnt;
  logic prev_we, b2b;

  token_decoder #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TOKEN_LEN(4)) dut (
    .clk(clk), .rst(rst), .cs(cs),
    .code_addr(code_addr), .code_dout(code_dout),
    .vocab_addr(vocab_addr), .vocab_dout(vocab_dout),
    .out_addr(out_addr), .out_din(out_din), .out_we(out_we),
    .done(done), .overflow(overflow)
`ifdef TOKEN_DECODER_COUNT_EN
    , .char_count(char_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    code_dout  <= code_mem[code_addr];
    vocab_dout <= vocab_mem[vocab_addr];
  end

  // Output RAM plus write-pulse bookkeeping; cleared by rst.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) out_mem[i] <= 8'hEE;
      we_cnt  <= 0;
      prev_we <= 1'b0;
      b2b     <= 1'b0;
    end else begin
      if (out_we) begin
        out_mem[out_addr] <= out_din;
        we_cnt <= we_cnt + 1;
      end
      if (out_we && prev_we) b2b <= 1'b1;
      prev_we <= out_we;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_out_we"},     32'(out_we),     0);
    check({pfx, "_done"},       32'(done),       0);
    check({pfx, "_overflow"},   32'(overflow),   0);
    check({pfx, "_code_addr"},  32'(code_addr),  0);
    check({pfx, "_vocab_addr"}, 32'(vocab_addr), 0);
    check({pfx, "_out_addr"},   32'(out_addr),   0);
    check({pfx, "_out_din"},    32'(out_din),    0);
`ifdef TOKEN_DECODER_COUNT_EN
    check({pfx, "_char_count"}, 32'(char_count), 0);
`endif
  endtask

  task automatic load_vocab();
    for (int i = 0; i < 16; i++) vocab_mem[i] = 8'h00;
    vocab_mem[4]  = 8'h61; vocab_mem[5]  = 8'h62;                 // "ab"
    vocab_mem[8]  = 8'h63; vocab_mem[9]  = 8'h64;
    vocab_mem[10] = 8'h65; vocab_mem[11] = 8'h66;                 // "cdef"
    vocab_mem[12] = 8'h67;                                        // "g"
  endtask

  task automatic load_codes(input logic [7:0] fill);
    for (int i = 0; i < 16; i++) code_mem[i] = fill;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cs  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Pulse cs, then wait (bounded) for done; optionally toggle cs while busy.
  task automatic run(input bit toggle);
    int n;
    cs = 1'b1;
    @(negedge clk);
    cs = 1'b0;
    n = 0;
    while (!done && n < 600) begin
      @(negedge clk);
      if (toggle) cs = ~cs;
      n++;
    end
    cs = 1'b0;
    if (!done) check("timeout_done", 32'(done), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_s1(input string pfx);
    logic [7:0] exp [8];
    exp = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h00};
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_out%0d", pfx, i), 32'(out_mem[i]), 32'(exp[i]));
    check({pfx, "_done"},     32'(done),     1);
    check({pfx, "_overflow"}, 32'(overflow), 0);
    check({pfx, "_we_cnt"},   32'(we_cnt),   8);
    check({pfx, "_b2b"},      32'(b2b),      0);
    check({pfx, "_unwritten"}, 32'(out_mem[8]), 32'h EE);
`ifdef TOKEN_DECODER_COUNT_EN
    check({pfx, "_char_count"}, 32'(char_count), 7);
`endif
  endtask

  initial begin
    int n;
    load_vocab();

    // Scenario 1: codes [1,2,3,0] -> "abcdefg\0"
    load_codes(8'h00);
    code_mem[0] = 8'd1; code_mem[1] = 8'd2; code_mem[2] = 8'd3;
    do_reset();
    check_outputs_zero("reset");
    run(1'b0);
    check_s1("s1");

    // Scenario 2: empty sequence -> single terminator, no vocab access
    load_codes(8'h00);
    do_reset();
    run(1'b0);
    check("s2_out0",     32'(out_mem[0]), 0);
    check("s2_out1",     32'(out_mem[1]), 32'hEE);
    check("s2_we_cnt",   32'(we_cnt),     1);
    check("s2_vaddr",    32'(vocab_addr), 0);
    check("s2_done",     32'(done),       1);
    check("s2_overflow", 32'(overflow),   0);

    // Scenario 3: four "cdef" tokens -> 15 chars then overflow, terminator at 15
    load_codes(8'h00);
    for (int i = 0; i < 4; i++) code_mem[i] = 8'd2;
    do_reset();
    run(1'b0);
    for (int i = 0; i < 15; i++)
      check($sformatf("s3_out%0d", i), 32'(out_mem[i]), 32'h63 + 32'(i % 4));
    check("s3_term",     32'(out_mem[15]), 0);
    check("s3_overflow", 32'(overflow),    1);
    check("s3_done",     32'(done),        1);
    check("s3_we_cnt",   32'(we_cnt),      16);
    check("s3_b2b",      32'(b2b),         0);

    // Scenario 4: code RAM all 1 ("ab") -> overflow hits before code RAM end
    load_codes(8'd1);
    do_reset();
    run(1'b0);
    for (int i = 0; i < 15; i++)
      check($sformatf("s4_out%0d", i), 32'(out_mem[i]), (i % 2 == 0) ? 32'h61 : 32'h62);
    check("s4_term",     32'(out_mem[15]), 0);
    check("s4_overflow", 32'(overflow),    1);
    check("s4_done",     32'(done),        1);

    // Scenario 5: all codes map to an empty slot -> code RAM exhausted, no overflow
    vocab_mem[12] = 8'h00;
    load_codes(8'd3);
    do_reset();
    run(1'b0);
    check("s5_out0",     32'(out_mem[0]), 0);
    check("s5_we_cnt",   32'(we_cnt),     1);
    check("s5_code_end", 32'(code_addr),  15);
    check("s5_overflow", 32'(overflow),   0);
    check("s5_done",     32'(done),       1);
    load_vocab();

    // Scenario 6: reset while the 'd' write of token 2 is on the bus
    load_codes(8'h00);
    code_mem[0] = 8'd1; code_mem[1] = 8'd2; code_mem[2] = 8'd3;
    do_reset();
    cs = 1'b1;
    @(negedge clk);
    cs = 1'b0;
    n = 0;
    while (we_cnt < 3 && n < 200) begin @(negedge clk); n++; end
    while (!out_we && n < 200) begin @(negedge clk); n++; end
    check("s6_pre_we", 32'(out_we), 1);
    check("s6_pre_din", 32'(out_din), 32'h64);
    rst = 1'b1;
    #1;
    check_outputs_zero("s6_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(1'b1);
    check_s1("s6_rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
